// File: rtl/pet_input_frontend.sv
// pet_input_frontend: synchronise/debounce buttons and LDR, detect test hold, run the ultrasonic ranger.
// Optional build macro PET_BTN_AUTOREPEAT_EN adds hold-to-repeat pulses on the feed and heal buttons.
module pet_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int TRIG_CYCLES     = 500,
    parameter int PERIOD_CYCLES   = 3_000_000,
    parameter int NEAR_CYCLES     = 29_000,
    parameter int ECHO_TIMEOUT    = 1_500_000
`ifdef PET_BTN_AUTOREPEAT_EN
    , parameter int REPEAT_CYCLES = 25_000_000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_feed_n,
    input  logic btn_heal_n,
    input  logic btn_state_n,
    input  logic btn_test_n,
    input  logic ldr_dark,
    input  logic echo_in,
    output logic trig,
    output logic feeding,
    output logic healing,
    output logic change_state,
    output logic test,
    output logic light_out,
    output logic echo_sig
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int EW = $clog2(ECHO_TIMEOUT + 1);
    // pin levels when nothing is happening: {echo, ldr, test, state, heal, feed}
    localparam logic [5:0] IDLE_LVL = 6'b001111;
    localparam logic [1:0] S_IDLE = 2'd0, S_TRIG = 2'd1, S_WAIT = 2'd2, S_MEAS = 2'd3;

    logic [5:0] sync1, sync2;
    logic [4:0] active, level, armed;
    logic [3:0] edgePrev, rose;
    logic [1:0] settle, repFire;
    logic [DW-1:0] dbCnt [5];
    logic [HW-1:0] testHold;
    logic testHeld, testDone;
    logic [1:0] state;
    logic [PW-1:0] periodCnt;
    logic [TW-1:0] trigCnt;
    logic [EW-1:0] echoCnt;
    logic echoNow, echoPrev, echoRise, periodWrap, nearFlag, resValid, resNear;

    // two-flop synchroniser, loading the idle pin levels in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= {echo_in, ldr_dark, btn_test_n, btn_state_n, btn_heal_n, btn_feed_n};
            sync2 <= sync1;
        end
    end

    assign active = sync2[4:0] ^ IDLE_LVL[4:0];

    // counts the synchroniser flush after reset so arming sees real pin levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) settle <= '0;
        else if (settle != 2'd3) settle <= settle + 2'd1;
    end

    // debounce each channel; a channel arms only once seen released after reset,
    // so a press held through reset never produces a pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) dbCnt[i] <= '0;
            level <= '0;
            armed <= '0;
            edgePrev <= '0;
        end else begin
            edgePrev <= {level[4], level[2:0]};
            armed <= armed | ({5{settle == 2'd3}} & ~level & ~active);
            for (int i = 0; i < 5; i++)
                if (active[i] == level[i]) dbCnt[i] <= '0;
                else if (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    dbCnt[i] <= '0;
                    level[i] <= active[i];
                end else dbCnt[i] <= dbCnt[i] + DW'(1);
        end
    end

    assign rose = {level[4], level[2:0]} & ~edgePrev & {armed[4], armed[2:0]};
    assign testHeld = level[3] & armed[3];

    // saturating hold timer for the test button; testDone blocks a second pulse until release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            testHold <= '0;
            testDone <= 1'b0;
        end else begin
            testHold <= !testHeld ? '0 : testHold == HW'(HOLD_CYCLES) ? testHold : testHold + HW'(1);
            testDone <= testHeld & (testDone | testHold == HW'(HOLD_CYCLES));
        end
    end

`ifdef PET_BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [HW-1:0] repHold [2];
    logic [RW-1:0] repCnt [2];

    // feed/heal repeat fires once the hold time is reached and then every repeat interval
    always_comb begin
        repFire = '0;
        for (int i = 0; i < 2; i++)
            repFire[i] = level[i] & armed[i] & repHold[i] == HW'(HOLD_CYCLES) & repCnt[i] == '0;
    end

    // hold timer then modular repeat interval counter, both cleared on release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                repHold[i] <= '0;
                repCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++)
                if (!(level[i] & armed[i])) begin
                    repHold[i] <= '0;
                    repCnt[i] <= '0;
                end else if (repHold[i] != HW'(HOLD_CYCLES)) repHold[i] <= repHold[i] + HW'(1);
                else repCnt[i] <= repCnt[i] == RW'(REPEAT_CYCLES - 1) ? '0 : repCnt[i] + RW'(1);
        end
    end
`else
    assign repFire = '0;
`endif

    // registered one-cycle event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            feeding <= 1'b0;
            healing <= 1'b0;
            change_state <= 1'b0;
            test <= 1'b0;
            light_out <= 1'b0;
        end else begin
            feeding <= rose[0] | repFire[0];
            healing <= rose[1] | repFire[1];
            change_state <= rose[2];
            test <= testHeld & testHold == HW'(HOLD_CYCLES) & ~testDone;
            light_out <= rose[3];
        end
    end

    assign echoNow = sync2[5];
    assign echoRise = echoNow & ~echoPrev;
    assign periodWrap = periodCnt == PW'(PERIOD_CYCLES - 1);
    assign trig = state == S_TRIG;

    // a measurement ends on echo timeout (far) or echo fall (near when short enough)
    always_comb begin
        resValid = (state == S_WAIT && !echoRise && echoCnt == EW'(ECHO_TIMEOUT - 1)) ||
                   (state == S_MEAS && (!echoNow || echoCnt == EW'(ECHO_TIMEOUT - 1)));
        resNear = state == S_MEAS && !echoNow && echoCnt < EW'(NEAR_CYCLES);
    end

    // ranger sequencing: trigger on each period wrap, time the echo, flag far-to-near
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            periodCnt <= '0;
            trigCnt <= '0;
            echoCnt <= '0;
            echoPrev <= 1'b0;
            nearFlag <= 1'b0;
            echo_sig <= 1'b0;
        end else begin
            echoPrev <= echoNow;
            periodCnt <= periodWrap ? '0 : periodCnt + PW'(1);
            echo_sig <= resValid & resNear & ~nearFlag;
            if (resValid) nearFlag <= resNear;
            case (state)
                S_IDLE: begin
                    trigCnt <= '0;
                    echoCnt <= '0;
                    if (periodWrap) state <= S_TRIG;
                end
                S_TRIG: begin
                    trigCnt <= trigCnt + TW'(1);
                    if (trigCnt == TW'(TRIG_CYCLES - 1)) state <= S_WAIT;
                end
                S_WAIT: begin
                    echoCnt <= echoRise ? '0 : echoCnt + EW'(1);
                    state <= echoRise ? S_MEAS : resValid ? S_IDLE : S_WAIT;
                end
                default: begin
                    echoCnt <= echoCnt + EW'(1);
                    if (resValid) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pet_input_frontend.sv
// tb_pet_input_frontend: directed checks of debounce, test hold, ranger and reset behaviour.
module tb_pet_input_frontend;
    logic clk = 1'b0;
    logic rst;
    logic btn_feed_n, btn_heal_n, btn_state_n, btn_test_n, ldr_dark, echo_in;
    logic trig, feeding, healing, change_state, test, light_out, echo_sig;
    logic [6:0] outs;
    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;
    int lastRise = 0;

    pet_input_frontend #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(20),
        .TRIG_CYCLES(2),
        .PERIOD_CYCLES(100),
        .NEAR_CYCLES(10),
        .ECHO_TIMEOUT(50)
`ifdef PET_BTN_AUTOREPEAT_EN
        , .REPEAT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_feed_n(btn_feed_n),
        .btn_heal_n(btn_heal_n),
        .btn_state_n(btn_state_n),
        .btn_test_n(btn_test_n),
        .ldr_dark(ldr_dark),
        .echo_in(echo_in),
        .trig(trig),
        .feeding(feeding),
        .healing(healing),
        .change_state(change_state),
        .test(test),
        .light_out(light_out),
        .echo_sig(echo_sig)
    );

    assign outs = {trig, echo_sig, light_out, test, change_state, healing, feeding};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int idx, input int n, output int cnt, output int first);
        cnt = 0;
        first = -1;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (outs[idx]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
    endtask

    task automatic rangeRound(input string tag, input int len, input int exp);
        int t, hi, cnt;
        t = 0;
        while (!trig && t < 300) begin
            tick();
            t++;
        end
        check({tag, "_trig_seen"}, trig, 1);
        if (lastRise != 0) check({tag, "_period"}, cyc - lastRise, 100);
        lastRise = cyc;
        hi = 0;
        while (trig && hi < 10) begin
            tick();
            hi++;
        end
        check({tag, "_trig_width"}, hi, 2);
        cnt = 0;
        for (int i = 0; i < 72; i++) begin
            echo_in = (i >= 2 && i < 2 + len);
            tick();
            if (echo_sig) cnt++;
        end
        echo_in = 1'b0;
        check({tag, "_echo_sig"}, cnt, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, first, t;
        int rep[$];
        int expRep[$];
        rst = 1'b0;
        {btn_feed_n, btn_heal_n, btn_state_n, btn_test_n} = 4'hF;
        ldr_dark = 1'b0;
        echo_in = 1'b0;
        repeat (3) tick();
        check("reset_outs", outs, 0);
        #3 rst = 1'b1;
        repeat (10) tick();

        // feed with two cycles of bounce; pulse 7 clk after the last edge
        btn_feed_n = 1'b0;
        tick();
        btn_feed_n = 1'b1;
        tick();
        btn_feed_n = 1'b0;
        watch(0, 28, cnt, first);
        check("feed_count", cnt, 1);
        check("feed_latency", first, 7);
        btn_feed_n = 1'b1;
        watch(0, 20, cnt, first);
        check("feed_release", cnt, 0);

        // test button: short hold gives nothing, long hold one pulse at 2+4+20+1
        btn_test_n = 1'b0;
        watch(3, 15, cnt, first);
        btn_test_n = 1'b1;
        watch(3, 15, t, first);
        check("test_short", cnt + t, 0);
        btn_test_n = 1'b0;
        watch(3, 40, cnt, first);
        check("test_long_count", cnt, 1);
        check("test_long_latency", first, 27);
        btn_test_n = 1'b1;
        watch(3, 15, cnt, first);
        check("test_release", cnt, 0);

        // light sensor: pulse only on light-to-dark
        ldr_dark = 1'b1;
        watch(4, 20, cnt, first);
        check("ldr_dark_count", cnt, 1);
        check("ldr_dark_latency", first, 7);
        ldr_dark = 1'b0;
        watch(4, 20, cnt, first);
        check("ldr_light", cnt, 0);

        btn_state_n = 1'b0;
        watch(2, 15, cnt, first);
        check("state_count", cnt, 1);
        btn_state_n = 1'b1;
        watch(2, 15, cnt, first);
        check("state_release", cnt, 0);

        // long feed hold: repeats at +20 then every 8 only in the autorepeat build
        btn_feed_n = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (feeding) rep.push_back(i);
            if (i == 52) btn_feed_n = 1'b1;
        end
`ifdef PET_BTN_AUTOREPEAT_EN
        expRep = '{7, 27, 35, 43, 51};
`else
        expRep = '{7};
`endif
        check("hold_feed_count", rep.size(), expRep.size());
        for (int i = 0; i < expRep.size() && i < rep.size(); i++)
            check($sformatf("hold_feed_%0d", i), rep[i], expRep[i]);
        repeat (15) tick();

        // reset during a press: outputs clear at once, held press is discarded
        btn_heal_n = 1'b0;
        t = 0;
        while (!healing && t < 20) begin
            tick();
            t++;
        end
        check("heal_before_rst", healing, 1);
        #2 rst = 1'b0;
        #1 check("rst_press_outs", outs, 0);
        tick();
        #3 rst = 1'b1;
        watch(1, 40, cnt, first);
        check("heal_held_after_rst", cnt, 0);
        btn_heal_n = 1'b1;
        watch(1, 20, cnt, first);
        check("heal_release_after_rst", cnt, 0);
        btn_heal_n = 1'b0;
        watch(1, 20, cnt, first);
        check("heal_repress", cnt, 1);
        btn_heal_n = 1'b1;
        repeat (15) tick();

        // ranger: near/far sequence, boundaries width 10 (far) and 8 (near)
        lastRise = 0;
        rangeRound("near1", 6, 1);
        rangeRound("near_again", 6, 0);
        rangeRound("far12", 12, 0);
        rangeRound("near2", 6, 1);
        rangeRound("no_echo", 0, 0);
        rangeRound("near3", 6, 1);
        rangeRound("width10", 11, 0);
        rangeRound("width8", 9, 1);

        // reset while trig is high
        t = 0;
        while (!trig && t < 300) begin
            tick();
            t++;
        end
        check("trig_before_rst", trig, 1);
        #2 rst = 1'b0;
        #1 check("rst_trig_outs", outs, 0);
        tick();
        #3 rst = 1'b1;

        // reset mid-measurement clears the near flag as well
        t = 0;
        while (!trig && t < 300) begin
            tick();
            t++;
        end
        while (trig && t < 310) begin
            tick();
            t++;
        end
        check("meas_trig_done", trig, 0);
        echo_in = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b0;
        #1 check("rst_meas_outs", outs, 0);
        echo_in = 1'b0;
        tick();
        #3 rst = 1'b1;
        lastRise = 0;
        rangeRound("post_rst", 6, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
